// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM command arbiter: command codes,
// data-owner encoding, default geometry and the debug view of internal state.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WR256 = 2'b01;
  localparam logic [1:0] CMD_RD32  = 2'b10;
  localparam logic [1:0] CMD_RD256 = 2'b11;

  localparam int         DEF_VID_BURSTS = 3072;
  localparam int         DEF_LINE_AW    = 12;
  localparam logic [2:0] DEF_VID_BASE   = 3'b100;

  typedef enum logic {
    OWN_VIDEO = 1'b0,
    OWN_CACHE = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   phase;
    logic   ack_idle;
    logic   resync_pending;
  } arb_dbg_t;

  // Fixed priority: video refill starves nobody for long because a 32-byte
  // burst is short, so it always wins over the 256-byte cache transfers.
  function automatic logic [1:0] pick_cmd(input logic vid_req,
                                          input logic wr_req,
                                          input logic rd_req);
    if (vid_req)     return CMD_RD32;
    else if (wr_req) return CMD_WR256;
    else if (rd_req) return CMD_RD256;
    else             return CMD_NOP;
  endfunction

endpackage

// File: rtl/sdram_cmd_arbiter_packer.sv
// vid_word_packer: pairs consecutive 16-bit SDRAM read half-words into one
// 32-bit video queue write (first half-word lands in the low half).
module vid_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [15:0] din,
  output logic [31:0] vq_data,
  output logic        vq_wen,
  output logic        phase
);

  logic [15:0] low_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase   <= 1'b0;
      low_q   <= '0;
      vq_data <= '0;
      vq_wen  <= 1'b0;
    end else begin
      vq_wen <= 1'b0;
      // A fresh video grant restarts pairing so a stale half never leaks in.
      if (clear) begin
        phase <= 1'b0;
      end else if (strobe) begin
        if (!phase) begin
          low_q <= din;
          phase <= 1'b1;
        end else begin
          vq_data <= {din, low_q};
          vq_wen  <= 1'b1;
          phase   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command arbiter: picks one command per cycle from video refill,
// cache write-back and cache fill, steers data strobes to the acknowledged
// owner and packs video half-words. Optional vsync re-alignment of the video
// address is built with `define ARB_VSYNC_RESYNC_EN.
//
// Handshake: sys_cmd is a level re-evaluated every cycle; the controller
// echoes the accepted code on sys_cmd_ack for one or more cycles and only the
// first nonzero cycle after an all-zero cycle counts as the acceptance.
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int         VID_BURSTS = DEF_VID_BURSTS,
  parameter logic [2:0] VID_BASE   = DEF_VID_BASE,
  parameter int         LINE_AW    = DEF_LINE_AW
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ARB_VSYNC_RESYNC_EN
  input  logic               vsync,
`endif
  input  logic               vq_almost_empty,
  input  logic               cache_wr_req,
  input  logic               cache_rd_req,
  input  logic [LINE_AW-1:0] wb_addr,
  input  logic [LINE_AW-1:0] fill_addr,
  output logic [1:0]         sys_cmd,
  output logic [17:0]        sys_addr,
  input  logic [1:0]         sys_cmd_ack,
  input  logic               sys_rd_data_valid,
  input  logic               sys_wr_data_valid,
  input  logic [15:0]        sys_dout,
  output logic               cache_write_data,
  output logic               cache_read_data,
  output logic [31:0]        vq_data,
  output logic               vq_wen,
  output logic [LINE_AW-1:0] vid_adr,
  output arb_dbg_t           dbg
);

  localparam logic [LINE_AW-1:0] VID_LAST = LINE_AW'(VID_BURSTS - 1);

  logic   ack_idle_q;
  logic   ack_take;
  logic   vid_take;
  owner_e owner_q;
  owner_e owner_d;
  logic   vid_strobe;
  logic   phase;
  logic   resync_pending;

  // Command register: one cycle from request level to sys_cmd.
  always_ff @(posedge clk) begin
    if (!rst) sys_cmd <= CMD_NOP;
    else      sys_cmd <= pick_cmd(vq_almost_empty, cache_wr_req, cache_rd_req);
  end

  always_comb begin
    sys_addr = '0;
    case (sys_cmd)
      CMD_WR256: sys_addr = 18'({wb_addr, 6'b0});
      CMD_RD32:  sys_addr = 18'({VID_BASE, vid_adr, 3'b0});
      CMD_RD256: sys_addr = 18'({fill_addr, 6'b0});
      default:   sys_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) ack_idle_q <= 1'b0;
    else      ack_idle_q <= (sys_cmd_ack == CMD_NOP);
  end

  assign ack_take = ack_idle_q && (sys_cmd_ack != CMD_NOP);
  assign vid_take = ack_take && (sys_cmd_ack == CMD_RD32);

  // Owner FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst) owner_q <= OWN_VIDEO;
    else      owner_q <= owner_d;
  end

  // Owner FSM: next state.
  always_comb begin
    owner_d = owner_q;
    if (ack_take) owner_d = (sys_cmd_ack == CMD_RD32) ? OWN_VIDEO : OWN_CACHE;
  end

  // Owner FSM: outputs. Strobes follow the owner latched before this cycle.
  always_comb begin
    cache_write_data = (owner_q == OWN_CACHE) && sys_rd_data_valid;
    cache_read_data  = (owner_q == OWN_CACHE) && sys_wr_data_valid;
    vid_strobe       = (owner_q == OWN_VIDEO) && sys_rd_data_valid;
  end

`ifdef ARB_VSYNC_RESYNC_EN
  logic vsync_q1;
  logic vsync_q2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vsync_q1       <= 1'b0;
      vsync_q2       <= 1'b0;
      resync_pending <= 1'b0;
    end else begin
      vsync_q1 <= vsync;
      vsync_q2 <= vsync_q1;
      if (vid_take)              resync_pending <= 1'b0;
      if (vsync_q1 && !vsync_q2) resync_pending <= 1'b1;
    end
  end
`else
  assign resync_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      vid_adr <= '0;
    end else if (vid_take) begin
      if (resync_pending || (vid_adr == VID_LAST)) vid_adr <= '0;
      else                                         vid_adr <= vid_adr + LINE_AW'(1);
    end
  end

  vid_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (vid_take),
    .strobe  (vid_strobe),
    .din     (sys_dout),
    .vq_data (vq_data),
    .vq_wen  (vq_wen),
    .phase   (phase)
  );

  always_comb begin
    dbg.owner          = owner_q;
    dbg.phase          = phase;
    dbg.ack_idle       = ack_idle_q;
    dbg.resync_pending = resync_pending;
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Bench for sdram_cmd_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the arbiter's rules.
module tb_sdram_cmd_arbiter;
  import sdram_arb_pkg::*;

  localparam int VB = 3072;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        vsync = 1'b0;
  logic        vq_almost_empty, cache_wr_req, cache_rd_req;
  logic [11:0] wb_addr, fill_addr;
  logic [1:0]  sys_cmd;
  logic [17:0] sys_addr;
  logic [1:0]  sys_cmd_ack;
  logic        sys_rd_data_valid, sys_wr_data_valid;
  logic [15:0] sys_dout;
  logic        cache_write_data, cache_read_data;
  logic [31:0] vq_data;
  logic        vq_wen;
  logic [11:0] vid_adr;
  arb_dbg_t    dbg;

  sdram_cmd_arbiter dut (
    .clk               (clk),
    .rst               (rst),
`ifdef ARB_VSYNC_RESYNC_EN
    .vsync             (vsync),
`endif
    .vq_almost_empty   (vq_almost_empty),
    .cache_wr_req      (cache_wr_req),
    .cache_rd_req      (cache_rd_req),
    .wb_addr           (wb_addr),
    .fill_addr         (fill_addr),
    .sys_cmd           (sys_cmd),
    .sys_addr          (sys_addr),
    .sys_cmd_ack       (sys_cmd_ack),
    .sys_rd_data_valid (sys_rd_data_valid),
    .sys_wr_data_valid (sys_wr_data_valid),
    .sys_dout          (sys_dout),
    .cache_write_data  (cache_write_data),
    .cache_read_data   (cache_read_data),
    .vq_data           (vq_data),
    .vq_wen            (vq_wen),
    .vid_adr           (vid_adr),
    .dbg               (dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int n_wen = 0;
  int n_crd = 0;

  int          m_cmd = 0;
  int          m_vid = 0;
  bit          m_own_cache = 1'b0;
  bit          m_idle = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_vs_prev = 1'b0;
  bit          exp_wen = 1'b0;
  logic [15:0] half_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_addr();
    case (m_cmd)
      1:       return int'(wb_addr) * 64;
      2:       return 4 * 32768 + m_vid * 8;
      3:       return int'(fill_addr) * 64;
      default: return 0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_step();
    exp_wen = 1'b0;
    if (!rst) begin
      m_cmd = 0; m_vid = 0; m_own_cache = 1'b0; m_idle = 1'b0;
      m_pend = 1'b0; m_vs_prev = 1'b0;
      half_q.delete(); exp_q.delete();
    end else begin
      if (!m_own_cache && sys_rd_data_valid) begin
        half_q.push_back(sys_dout);
        if (half_q.size() == 2) begin
          exp_q.push_back({half_q[1], half_q[0]});
          half_q.delete();
          exp_wen = 1'b1;
        end
      end
      if (vq_almost_empty)   m_cmd = 2;
      else if (cache_wr_req) m_cmd = 1;
      else if (cache_rd_req) m_cmd = 3;
      else                   m_cmd = 0;
      if (m_idle && sys_cmd_ack != 2'b00) begin
        if (sys_cmd_ack == 2'b10) begin
          m_own_cache = 1'b0;
          half_q.delete();
          m_vid = m_pend ? 0 : (m_vid + 1) % VB;
          m_pend = 1'b0;
        end else begin
          m_own_cache = 1'b1;
        end
      end
      m_idle = (sys_cmd_ack == 2'b00);
`ifdef ARB_VSYNC_RESYNC_EN
      if (vsync && !m_vs_prev) m_pend = 1'b1;
      m_vs_prev = vsync;
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are changed at the falling edge; combinational outputs are checked
  // 1 time unit later, registered outputs at the next falling edge.
  task automatic cycle();
    logic [31:0] w;
    #1;
    check_eq("sys_addr", sys_addr, exp_addr());
    check_eq("cache_write_data", cache_write_data, m_own_cache & sys_rd_data_valid);
    check_eq("cache_read_data", cache_read_data, m_own_cache & sys_wr_data_valid);
    if (cache_read_data) n_crd++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("sys_cmd", sys_cmd, m_cmd);
    check_eq("vid_adr", vid_adr, m_vid);
    check_eq("owner", dbg.owner == OWN_CACHE, m_own_cache);
    check_eq("phase", dbg.phase, half_q.size() == 1);
    check_eq("vq_wen", vq_wen, exp_wen);
    if (vq_wen) begin
      n_wen++;
      got_q.push_back(vq_data);
    end
    if (exp_wen) begin
      w = exp_q.pop_front();
      if (vq_wen) check_eq("vq_data", vq_data, w);
    end
  endtask

  task automatic send_ack(input logic [1:0] code, input int hold);
    sys_cmd_ack = code;
    repeat (hold) cycle();
    sys_cmd_ack = 2'b00;
    cycle();
  endtask

  task automatic rd_strobes(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        sys_rd_data_valid = 1'b0;
        cycle();
      end
      sys_rd_data_valid = 1'b1;
      sys_dout = rnd ? 16'($urandom) : 16'(i);
      cycle();
    end
    sys_rd_data_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int hold;
    vq_almost_empty = 0; cache_wr_req = 0; cache_rd_req = 0;
    wb_addr = '0; fill_addr = '0; sys_cmd_ack = 2'b00;
    sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cycle();
    check_eq("rst_phase", dbg.phase, 1'b0);
    rst = 1'b1;
    repeat (10) cycle();

    // Priority with all three requesters asserted, then dropped one by one.
    wb_addr = 12'($urandom); fill_addr = 12'($urandom);
    vq_almost_empty = 1; cache_wr_req = 1; cache_rd_req = 1;
    cycle();
    check_eq("prio_vid", sys_cmd, CMD_RD32);
    vq_almost_empty = 0;
    cycle();
    check_eq("prio_wr", sys_cmd, CMD_WR256);
    cache_wr_req = 0;
    cycle();
    check_eq("prio_rd", sys_cmd, CMD_RD256);
    check_eq("prio_rd_addr", sys_addr, int'(fill_addr) * 64);
    cache_rd_req = 0;
    cycle();

    // Video burst with a 3-cycle ack and ramp data.
    n_wen = 0; got_q.delete();
    send_ack(CMD_RD32, 3);
    rd_strobes(16, 1'b0);
    cycle(); cycle();
    check_eq("burst_writes", n_wen, 8);
    check_eq("burst_first", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h00010000);
    check_eq("burst_last", got_q.size() > 7 ? got_q[7] : 32'hx, 32'h000F000E);
    check_eq("burst_vid_adr", vid_adr, 1);

    // Cache write-back then cache fill steering.
    n_wen = 0; n_crd = 0;
    send_ack(CMD_WR256, 1);
    for (int i = 0; i < 128; i++) begin
      sys_wr_data_valid = 1'b1;
      cycle();
    end
    sys_wr_data_valid = 1'b0;
    cycle();
    check_eq("cache_rd_pulses", n_crd, 128);
    check_eq("cache_no_vq_wen", n_wen, 0);
    send_ack(CMD_RD256, 2);
    for (int i = 0; i < 40; i++) begin
      sys_rd_data_valid = 1'($urandom_range(0, 1));
      sys_dout = 16'($urandom);
      cycle();
    end
    sys_rd_data_valid = 1'b0;
    cycle();
    check_eq("fill_no_vq_wen", n_wen, 0);

    // Reset in the middle of a video burst abandons the odd half-word.
    send_ack(CMD_RD32, 1);
    n_wen = 0;
    rd_strobes(5, 1'b0);
    check_eq("pre_rst_writes", n_wen, 2);
    rst = 1'b0;
    n_wen = 0;
    cycle();
    check_eq("rst_mid_phase", dbg.phase, 1'b0);
    rst = 1'b1;
    cycle(); cycle();
    check_eq("rst_no_partial", n_wen, 0);
    check_eq("rst_vid_adr", vid_adr, 0);
    send_ack(CMD_RD32, 2);
    rd_strobes(16, 1'b1);
    cycle(); cycle();
    check_eq("post_rst_writes", n_wen, 8);

    // Random traffic; strobes only while no ack is on the bus.
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      vq_almost_empty = ($urandom_range(0, 3) == 0);
      cache_wr_req = 1'($urandom_range(0, 1));
      cache_rd_req = 1'($urandom_range(0, 1));
      wb_addr = 12'($urandom); fill_addr = 12'($urandom);
      if (hold > 0) hold--;
      else if (sys_cmd_ack != 2'b00) sys_cmd_ack = 2'b00;
      else if ($urandom_range(0, 5) == 0) begin
        sys_cmd_ack = 2'($urandom_range(1, 3));
        hold = $urandom_range(0, 2);
      end
      sys_rd_data_valid = (sys_cmd_ack == 2'b00) && ($urandom_range(0, 1) == 1);
      sys_wr_data_valid = (sys_cmd_ack == 2'b00) && ($urandom_range(0, 2) == 0);
      sys_dout = 16'($urandom);
      cycle();
    end
    vq_almost_empty = 0; cache_wr_req = 0; cache_rd_req = 0;
    sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_cmd_ack = 2'b00;
    cycle(); cycle();

    // Walk the video address up to its last burst, then wrap.
    for (int i = 0; i < VB && m_vid != VB - 1; i++) send_ack(CMD_RD32, 1);
    check_eq("pre_wrap_vid", vid_adr, VB - 1);
    send_ack(CMD_RD32, 1);
    check_eq("wrap_vid", vid_adr, 0);
    vq_almost_empty = 1;
    cycle();
    check_eq("wrap_addr", sys_addr, 18'h20000);
    vq_almost_empty = 0;
    cycle();

`ifdef ARB_VSYNC_RESYNC_EN
    for (int i = 0; i < VB && m_vid != 100; i++) send_ack(CMD_RD32, 1);
    check_eq("pre_resync_vid", vid_adr, 100);
    vsync = 1'b1;
    cycle(); cycle();
    vsync = 1'b0;
    repeat (3) cycle();
    send_ack(CMD_RD32, 1);
    check_eq("resync_vid", vid_adr, 0);
    send_ack(CMD_RD32, 1);
    check_eq("resync_cleared", vid_adr, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
